// File: rtl/loanio_uart_tx.sv
// rtl/loanio_uart_tx.sv - UART 8N1 transmitter with byte FIFO driving one HPS loan-IO pin
module loanio_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int LOANIO_BIT = 49,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        busy,
  output logic [66:0] loan_io_out,
  output logic [66:0] loan_io_oe
);

  // Bit period in clock cycles, rounded to nearest.
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("loanio_uart_tx: baud divisor must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("loanio_uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (LOANIO_BIT < 0 || LOANIO_BIT > 66) begin : g_bad_pin
      $error("loanio_uart_tx: LOANIO_BIT must be in 0..66");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          line;
  logic          bit_end;

  assign empty    = (count == '0);
  assign full     = (count == FULL_COUNT);
  assign tx_ready = !full;
  assign push     = tx_valid && tx_ready;
  assign bit_end  = (cnt == CNT_LAST);
  // The head is taken either from an idle machine or at the very end of a stop
  // bit, the latter letting frames run back-to-back without an idle cycle.
  assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_end));
  assign busy     = (state != IDLE) || !empty;

  // Byte storage, written on every accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame state machine; the line register follows the state one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      line    <= 1'b1;
    end else begin
      case (state)
        START:   line <= 1'b0;
        DATA:    line <= shift[0];
        default: line <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            shift <= mem[rd_ptr];
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the loaned pin carries the line; every other bit stays low
  always_comb begin
    loan_io_out             = '0;
    loan_io_out[LOANIO_BIT] = line;
  end

  // The loaned pin is permanently an output
  always_comb begin
    loan_io_oe             = '0;
    loan_io_oe[LOANIO_BIT] = 1'b1;
  end

endmodule
